// File: rtl/fpu_exc_pkg.sv
// Shared definitions for the FP exception unit: op codes, exception codes, sticky bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fpu_exc_pkg;

  // FP_OPERATION encoding
  localparam logic [1:0] _ADDITION       = 2'b00;
  localparam logic [1:0] _SUBTRACTION    = 2'b01;
  localparam logic [1:0] _MULTIPLICATION = 2'b10;
  localparam logic [1:0] _DIVISION       = 2'b11;

  // Exception code driven on OUT_EXCE; 5-7 are never produced
  typedef enum logic [2:0] {
    NO_EXCE   = 3'd0,
    qNAN_EXCE = 3'd1,
    sNAN_EXCE = 3'd2,
    INV_EXCE  = 3'd3,
    ZDIV_EXCE = 3'd4
  } exce_e;

  // Bit positions inside STICKY_FLAGS
  localparam int STK_INV  = 0;
  localparam int STK_ZDIV = 1;
  localparam int STK_QNAN = 2;
  localparam int STK_SNAN = 3;

  // One-hot sticky bit for an exception code; NO_EXCE sets nothing
  function automatic logic [3:0] sticky_mask(input exce_e code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      INV_EXCE:  m[STK_INV]  = 1'b1;
      ZDIV_EXCE: m[STK_ZDIV] = 1'b1;
      qNAN_EXCE: m[STK_QNAN] = 1'b1;
      sNAN_EXCE: m[STK_SNAN] = 1'b1;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Classifies one minifloat operand (NaN quiet/signalling, infinity, zero, sign).
// Latency: purely combinational.
// Backpressure: none, no state.
module fp_class_decode #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic [EXP_W+MAN_W:0] fp,
  output logic                 is_nan,
  output logic                 is_qnan,
  output logic                 is_snan,
  output logic                 is_inf,
  output logic                 is_zero,
  output logic                 sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign exp_f    = fp[MAN_W +: EXP_W];
  assign man_f    = fp[MAN_W-1:0];
  assign sign     = fp[EXP_W+MAN_W];
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign man_zero = ~|man_f;

  // Subnormals (exp 0, mantissa non-zero) deliberately do not count as zero
  assign is_nan  = exp_ones & ~man_zero;
  assign is_qnan = is_nan &  man_f[MAN_W-1];
  assign is_snan = is_nan & ~man_f[MAN_W-1];
  assign is_inf  = exp_ones & man_zero;
  assign is_zero = exp_zero & man_zero;

endmodule

// File: rtl/fp_exception_unit.sv
// Detects IEEE-style exceptions for add/sub/mul/div and keeps sticky flags plus a saturating count.
// Latency: 1 cycle from accept to OUT_VALID; throughput 1 op per cycle.
// Backpressure: single output register; IN_READY = !OUT_VALID || OUT_READY, result held while stalled.
module fp_exception_unit
  import fpu_exc_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [1:0]           FP_OPERATION,
  input  logic [EXP_W+MAN_W:0] OP_A,
  input  logic [EXP_W+MAN_W:0] OP_B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OP_IS_EXCEPTION,
  output logic [2:0]           OUT_EXCE,
  output logic [3:0]           STICKY_FLAGS,
  input  logic                 CLR_STICKY,
  output logic [CNT_W-1:0]     EXC_COUNT
);

  logic a_nan, a_qnan, a_snan, a_inf, a_zero, a_sign;
  logic b_nan, b_qnan, b_snan, b_inf, b_zero, b_sign;
  exce_e code_nxt;
  logic  accept;
  logic  out_vld_q;
  logic  out_exc_q;
  logic [2:0]       out_exce_q;
  logic [3:0]       sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       sticky_base;
  logic [CNT_W-1:0] cnt_base;

  fp_class_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_a (
    .fp(OP_A), .is_nan(a_nan), .is_qnan(a_qnan), .is_snan(a_snan),
    .is_inf(a_inf), .is_zero(a_zero), .sign(a_sign)
  );

  fp_class_decode #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_dec_b (
    .fp(OP_B), .is_nan(b_nan), .is_qnan(b_qnan), .is_snan(b_snan),
    .is_inf(b_inf), .is_zero(b_zero), .sign(b_sign)
  );

  assign IN_READY = !out_vld_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  // Prioritised exception code: sNaN, then qNaN, then per-operation invalid/div-by-zero
  always_comb begin
    code_nxt = NO_EXCE;
    if (a_snan || b_snan) begin
      code_nxt = sNAN_EXCE;
    end else if (a_qnan || b_qnan) begin
      code_nxt = qNAN_EXCE;
    end else if (!(a_nan || b_nan)) begin
      case (FP_OPERATION)
        _ADDITION:
          if (a_inf && b_inf && (a_sign != b_sign)) code_nxt = INV_EXCE;
        _SUBTRACTION:
          if (a_inf && b_inf && (a_sign == b_sign)) code_nxt = INV_EXCE;
        _MULTIPLICATION:
          if ((a_zero && b_inf) || (a_inf && b_zero)) code_nxt = INV_EXCE;
        default: begin
          // inf/0 falls through to div-by-zero, not invalid
          if ((a_zero && b_zero) || (a_inf && b_inf)) code_nxt = INV_EXCE;
          else if (b_zero)                             code_nxt = ZDIV_EXCE;
        end
      endcase
    end
  end

  // Output register: load on accept, drop valid once taken without a refill
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_vld_q  <= 1'b0;
      out_exc_q  <= 1'b0;
      out_exce_q <= NO_EXCE;
    end else if (accept) begin
      out_vld_q  <= 1'b1;
      out_exc_q  <= (code_nxt != NO_EXCE);
      out_exce_q <= code_nxt;
    end else if (OUT_READY) begin
      out_vld_q  <= 1'b0;
    end
  end

  // Clear acts first so an exception accepted in the same cycle survives it
  assign sticky_base = CLR_STICKY ? 4'b0000 : sticky_q;
  assign cnt_base    = CLR_STICKY ? '0 : cnt_q;

  // Sticky flags and saturating exception counter, updated on accepted ops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_q <= 4'b0000;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_base | (accept ? sticky_mask(code_nxt) : 4'b0000);
      if (accept && (code_nxt != NO_EXCE) && (cnt_base != {CNT_W{1'b1}}))
        cnt_q <= cnt_base + 1'b1;
      else
        cnt_q <= cnt_base;
    end
  end

  assign OUT_VALID       = out_vld_q;
  assign OP_IS_EXCEPTION = out_exc_q;
  assign OUT_EXCE        = out_exce_q;
  assign STICKY_FLAGS    = sticky_q;
  assign EXC_COUNT       = cnt_q;

endmodule

// File: tb/tb_fp_exception_unit.sv
// Directed bench for fp_exception_unit: vector table plus handshake, sticky and reset sequences.
// Latency: checks results one cycle after each accept.
// Backpressure: exercises stalled OUT_READY and back-to-back accepts.
module tb_fp_exception_unit;

  logic       CLK;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [1:0] FP_OPERATION;
  logic [7:0] OP_A;
  logic [7:0] OP_B;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       OP_IS_EXCEPTION;
  logic [2:0] OUT_EXCE;
  logic [3:0] STICKY_FLAGS;
  logic       CLR_STICKY;
  logic [7:0] EXC_COUNT;

  logic       sat_in_valid;
  logic       sat_in_ready;
  logic       sat_out_valid;
  logic       sat_op_is_exc;
  logic [2:0] sat_out_exce;
  logic [3:0] sat_sticky;
  logic [1:0] sat_count;

  int n_chk;
  int n_fail;
  logic [3:0] m_stk;
  logic [7:0] m_cnt;

  fp_exception_unit #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OP_IS_EXCEPTION(OP_IS_EXCEPTION), .OUT_EXCE(OUT_EXCE),
    .STICKY_FLAGS(STICKY_FLAGS), .CLR_STICKY(CLR_STICKY), .EXC_COUNT(EXC_COUNT)
  );

  fp_exception_unit #(.EXP_W(4), .MAN_W(3), .CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .IN_VALID(sat_in_valid), .IN_READY(sat_in_ready),
    .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
    .OUT_VALID(sat_out_valid), .OUT_READY(OUT_READY),
    .OP_IS_EXCEPTION(sat_op_is_exc), .OUT_EXCE(sat_out_exce),
    .STICKY_FLAGS(sat_sticky), .CLR_STICKY(CLR_STICKY), .EXC_COUNT(sat_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] exp_code;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] exp_mask(input logic [2:0] c);
    case (c)
      3'd1:    return 4'b0100;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  // Accepted op: fold into the reference sticky/count model
  task automatic model_accept(input logic [2:0] c);
    m_stk = m_stk | exp_mask(c);
    if (c != 3'd0 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] c);
    chk({tag, " out_valid"}, 32'(OUT_VALID), 32'd1);
    chk({tag, " out_exce"}, 32'(OUT_EXCE), 32'(c));
    chk({tag, " op_is_exception"}, 32'(OP_IS_EXCEPTION), 32'(c != 3'd0));
    chk({tag, " sticky"}, 32'(STICKY_FLAGS), 32'(m_stk));
    chk({tag, " exc_count"}, 32'(EXC_COUNT), 32'(m_cnt));
  endtask

  task automatic apply_vec(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] c, input string tag);
    @(negedge CLK);
    FP_OPERATION = op; OP_A = a; OP_B = b;
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    model_accept(c);
    check_out(tag, c);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_stk = 4'b0000; m_cnt = 8'd0;
    RST = 1'b1; IN_VALID = 1'b0; sat_in_valid = 1'b0; OUT_READY = 1'b1;
    CLR_STICKY = 1'b0; FP_OPERATION = 2'b00; OP_A = 8'h00; OP_B = 8'h00;

    // op, a, b, expected code
    vecs[0]  = '{2'd0, 8'h78, 8'hF8, 3'd3}; // +inf + -inf
    vecs[1]  = '{2'd0, 8'h38, 8'h38, 3'd0}; // 1 + 1
    vecs[2]  = '{2'd0, 8'h7C, 8'h79, 3'd2}; // qNaN + sNaN -> sNaN wins
    vecs[3]  = '{2'd2, 8'h7C, 8'h00, 3'd1}; // qNaN * 0 -> qNaN, not invalid
    vecs[4]  = '{2'd1, 8'hF8, 8'hF8, 3'd3}; // -inf - -inf
    vecs[5]  = '{2'd1, 8'hF8, 8'h78, 3'd0}; // -inf - +inf
    vecs[6]  = '{2'd2, 8'h80, 8'hF8, 3'd3}; // -0 * -inf
    vecs[7]  = '{2'd3, 8'h00, 8'h80, 3'd3}; // 0 / -0
    vecs[8]  = '{2'd3, 8'h78, 8'hF8, 3'd3}; // inf / inf
    vecs[9]  = '{2'd3, 8'h38, 8'h00, 3'd4}; // 1 / 0
    vecs[10] = '{2'd3, 8'h78, 8'h00, 3'd4}; // inf / 0
    vecs[11] = '{2'd3, 8'h00, 8'h38, 3'd0}; // 0 / 1
    vecs[12] = '{2'd0, 8'h78, 8'h78, 3'd0}; // +inf + +inf
    vecs[13] = '{2'd1, 8'h78, 8'hF8, 3'd0}; // +inf - -inf
    vecs[14] = '{2'd2, 8'h38, 8'h78, 3'd0}; // 1 * inf
    vecs[15] = '{2'd3, 8'h79, 8'h00, 3'd2}; // sNaN / 0 -> sNaN over div-by-zero
    vecs[16] = '{2'd3, 8'h38, 8'h01, 3'd0}; // divide by subnormal is not div-by-zero
    vecs[17] = '{2'd2, 8'h01, 8'hF8, 3'd0}; // subnormal * inf is not invalid

    #2;
    chk("reset out_valid", 32'(OUT_VALID), 32'd0);
    chk("reset op_is_exception", 32'(OP_IS_EXCEPTION), 32'd0);
    chk("reset out_exce", 32'(OUT_EXCE), 32'd0);
    chk("reset sticky", 32'(STICKY_FLAGS), 32'd0);
    chk("reset exc_count", 32'(EXC_COUNT), 32'd0);
    chk("reset in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 18; i++)
      apply_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_code, $sformatf("vec%0d", i));

    // Drain, then stall with the input held valid
    @(negedge CLK);
    chk("idle out_valid", 32'(OUT_VALID), 32'd0);
    FP_OPERATION = 2'd0; OP_A = 8'h78; OP_B = 8'hF8;
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(negedge CLK);
    model_accept(3'd3);
    check_out("stall first", 3'd3);
    chk("stall in_ready", 32'(IN_READY), 32'd0);
    FP_OPERATION = 2'd3; OP_A = 8'h38; OP_B = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check_out($sformatf("stall hold%0d", k), 3'd3);
      chk($sformatf("stall hold%0d in_ready", k), 32'(IN_READY), 32'd0);
    end
    OUT_READY = 1'b1;
    #1;
    chk("release in_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    model_accept(3'd4);
    check_out("b2b div", 3'd4);
    FP_OPERATION = 2'd0; OP_A = 8'h38; OP_B = 8'h38;
    @(negedge CLK);
    model_accept(3'd0);
    check_out("b2b add", 3'd0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("b2b drained", 32'(OUT_VALID), 32'd0);

    // Clear alone, then clear together with an exceptional accept
    CLR_STICKY = 1'b1;
    @(negedge CLK);
    CLR_STICKY = 1'b0;
    chk("clr sticky", 32'(STICKY_FLAGS), 32'd0);
    chk("clr exc_count", 32'(EXC_COUNT), 32'd0);
    CLR_STICKY = 1'b1; IN_VALID = 1'b1;
    FP_OPERATION = 2'd3; OP_A = 8'h38; OP_B = 8'h00;
    @(negedge CLK);
    CLR_STICKY = 1'b0; IN_VALID = 1'b0;
    m_stk = 4'b0010; m_cnt = 8'd1;
    check_out("clr+zdiv", 3'd4);

    // Saturation on the 2-bit counter instance
    FP_OPERATION = 2'd0; OP_A = 8'h78; OP_B = 8'hF8;
    sat_in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      chk($sformatf("sat count op%0d", k), 32'(sat_count), (k > 3) ? 32'd3 : 32'(k));
    end
    sat_in_valid = 1'b0;
    chk("sat sticky", 32'(sat_sticky), 32'd1);

    // Asynchronous reset while a result is held
    @(negedge CLK);
    FP_OPERATION = 2'd0; OP_A = 8'h7C; OP_B = 8'h79;
    IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("pre-reset out_valid", 32'(OUT_VALID), 32'd1);
    chk("pre-reset out_exce", 32'(OUT_EXCE), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    chk("async rst out_valid", 32'(OUT_VALID), 32'd0);
    chk("async rst op_is_exception", 32'(OP_IS_EXCEPTION), 32'd0);
    chk("async rst out_exce", 32'(OUT_EXCE), 32'd0);
    chk("async rst sticky", 32'(STICKY_FLAGS), 32'd0);
    chk("async rst exc_count", 32'(EXC_COUNT), 32'd0);
    chk("async rst sat count", 32'(sat_count), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("post-reset out_valid", 32'(OUT_VALID), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
